// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - req/ack bus between the MEM stage and data memory / IO space.
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic        bus_io;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_io,
    output bus_addr,
    output bus_wdata,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_io,
    input  bus_addr,
    input  bus_wdata,
    output bus_ack,
    output bus_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM stage: one bus transaction per load/store with stall and timeout,
// plus branch/jump/jalr resolution producing the PC redirect and upstream Flush.
module mem_access_unit #(
  parameter int unsigned TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               mem_valid,
  input  logic               MEM_MemRead,
  input  logic               MEM_MemWrite,
  input  logic               MEM_ioRead,
  input  logic               MEM_ioWrite,
  input  logic               MEM_Branch,
  input  logic               MEM_zero,
  input  logic               MEM_Jump,
  input  logic               MEM_Jalr,
  input  logic [31:0]        MEM_ALUResult,
  input  logic [31:0]        MEM_rs2_v,
  input  logic [31:0]        MEM_addr_in,
  input  logic [31:0]        MEM_imm32,
  mem_access_unit_if.master  bus,
  output logic               stall,
  output logic               load_valid,
  output logic [31:0]        load_data,
  output logic               pc_redirect,
  output logic [31:0]        pc_target,
  output logic               Flush,
  output logic               err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic [7:0]  cnt_q;
  logic        req_q;
  logic        we_q;
  logic        io_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        lv_q;
  logic [31:0] ld_q;
  logic        err_q;

  logic        acc;
  logic        acc_we;
  logic        acc_io;
  logic        in_idle;
  logic        taken;

  assign acc     = mem_valid & (MEM_MemRead | MEM_MemWrite | MEM_ioRead | MEM_ioWrite);
  assign acc_we  = MEM_MemWrite | MEM_ioWrite;
  assign acc_io  = MEM_ioRead | MEM_ioWrite;
  assign in_idle = (state_q == S_IDLE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      io_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      lv_q    <= 1'b0;
      ld_q    <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      lv_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (acc) begin
            addr_q  <= MEM_ALUResult;
            wdata_q <= MEM_rs2_v;
            we_q    <= acc_we;
            io_q    <= acc_io;
            req_q   <= 1'b1;
            cnt_q   <= 8'd0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.bus_ack) begin
            req_q   <= 1'b0;
            lv_q    <= 1'b1;
            state_q <= S_DONE;
            if (!we_q) ld_q <= bus.bus_rdata;
          end else if (cnt_q == CNT_LAST) begin
            // Abort: the stage still completes so the pipeline cannot deadlock.
            req_q   <= 1'b0;
            lv_q    <= 1'b1;
            err_q   <= 1'b1;
            state_q <= S_DONE;
            if (!we_q) ld_q <= ERR_DATA;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall = in_idle ? acc : (state_q == S_WAIT);

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_io    = io_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;

  assign load_valid = lv_q;
  assign load_data  = ld_q;
  assign err        = err_q;

  // Control flow only resolves on the first MEM cycle, so a stalled access never re-flushes.
  assign taken       = in_idle & mem_valid & (MEM_Jump | (MEM_Branch & MEM_zero));
  assign pc_redirect = taken;
  assign Flush       = taken;
  assign pc_target   = (taken & MEM_Jalr) ? {MEM_ALUResult[31:1], 1'b0}
                                          : (MEM_addr_in + MEM_imm32);

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Runs data-memory and IO load/store transactions over a req/ack bus, stalling the pipeline until each completes.
- Resolves branch, jump and jalr control flow in MEM, producing the PC redirect and the Flush that clears upstream stage registers.

Parameters:
- TIMEOUT, 16: max WAIT cycles without ack before abort; legal range 2..255.
- ERR_DATA, 32'h0000_0000: value returned on load_data when a load is aborted.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- mem_valid  in  1  MEM stage holds a live instruction
- MEM_MemRead, MEM_MemWrite, MEM_ioRead, MEM_ioWrite  in  1 each  access controls
- MEM_Branch, MEM_zero, MEM_Jump, MEM_Jalr  in  1 each  control-flow controls
- MEM_ALUResult  in  32  access address / jalr target
- MEM_rs2_v  in  32  store data
- MEM_addr_in  in  32  instruction PC
- MEM_imm32  in  32  branch/jal offset
- bus_req  out  1  transaction request
- bus_we  out  1  1 = write
- bus_io  out  1  1 = IO space, 0 = data memory
- bus_addr  out  32  address
- bus_wdata  out  32  write data
- bus_ack  in  1  transaction complete
- bus_rdata  in  32  read data, valid with bus_ack
- stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- load_valid  out  1  load_data valid for MEM/WB capture
- load_data  out  32  loaded word
- pc_redirect  out  1  take pc_target
- pc_target  out  32  redirect target
- Flush  out  1  clear IF/ID, ID/EX, EX/MEM
- err  out  1  sticky timeout flag

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE, timeout counter=0. bus_req, bus_we, bus_io, bus_addr, bus_wdata, load_valid, load_data, err all 0. Reset mid-transaction abandons it; bus_req drops at that edge.
- acc = mem_valid & (MEM_MemRead | MEM_MemWrite | MEM_ioRead | MEM_ioWrite).
- we = MEM_MemWrite | MEM_ioWrite; write wins if read and write are both set.
- io = MEM_ioRead | MEM_ioWrite.
- FSM state IDLE:
  - stall = acc (combinational).
  - If acc: register bus_addr=MEM_ALUResult, bus_wdata=MEM_rs2_v, bus_we=we, bus_io=io; set bus_req=1, counter=0; go WAIT.
- FSM state WAIT:
  - stall=1; bus_req and all bus fields held stable.
  - bus_ack=1: bus_req<=0; if read, load_data<=bus_rdata; go DONE.
  - Otherwise counter++. When counter reaches TIMEOUT-1 without ack: bus_req<=0, err<=1, load_data<=ERR_DATA on reads; go DONE.
- FSM state DONE:
  - stall=0, load_valid=1 for exactly this cycle (also for writes, where load_data holds its previous value); pipeline advances.
  - Next state IDLE.
  - DONE never re-issues, so each instruction makes exactly one request.
- Latency: ack in the same cycle bus_req first rises gives 2 stall cycles (IDLE, WAIT) plus DONE. General case: ack-cycle-index + 1 stall cycles.
- bus_ack outside WAIT is ignored. bus_rdata is sampled only with bus_ack.
- Control flow, combinational, qualified by state==IDLE & mem_valid:
  - taken = MEM_Jump | (MEM_Branch & MEM_zero).
  - pc_redirect = Flush = taken.
  - pc_target = MEM_Jalr ? {MEM_ALUResult[31:1],1'b0} : MEM_addr_in + MEM_imm32, 32-bit wrap, no overflow detection.
  - When not taken, pc_target = MEM_addr_in + MEM_imm32 and is don't-care.
- err clears only on reset.

Test Plan:
- Load, ack on 3rd WAIT cycle: mem_valid=1, MemRead=1, ALUResult=32'h0000_0040, bus_rdata=32'h1234_5678 -> bus_req high 3 cycles with bus_addr=32'h40, bus_we=0, bus_io=0; stall high 4 cycles; load_valid pulses once with load_data=32'h1234_5678.
- IO store, immediate ack: ioWrite=1, ALUResult=32'hFFFF_FC60, rs2_v=32'hA5 -> bus_io=1, bus_we=1, bus_wdata=32'hA5; exactly one request; stall high 2 cycles.
- Timeout, TIMEOUT=4, bus_ack held 0 on a load -> bus_req drops after 4 WAIT cycles; err=1 and stays 1; load_data=ERR_DATA.
- Branch and jalr resolution:
  - Branch=1, zero=1, addr_in=32'h100, imm32=32'hFFFF_FFF8 -> Flush=1, pc_target=32'hF8.
  - Jalr=1, Jump=1, ALUResult=32'h203 -> pc_target=32'h202.
  - Branch=1, zero=0 -> Flush=0.
- Reset mid-WAIT: rstn=0 for one cycle during WAIT -> next cycle bus_req=0, stall=0, err=0; a late bus_ack is ignored and load_valid stays 0.
